// File: rtl/fp_wb_normalize_pkg.sv
// Shared FP writeback types: widths, the intermediate result fed into normalization
// and the normalized, not-yet-rounded operand handed to the rounding stage.
package fpu_types;

  localparam int EXPO_WIDTH = 11;
  localparam int FRAC_WIDTH = 52;
  localparam int GRS_WIDTH  = FRAC_WIDTH + 3;
  localparam int ID_WIDTH   = 3;

  localparam int EXP_W   = EXPO_WIDTH + 2;
  localparam int MANT_W  = FRAC_WIDTH + 1;
  // {carry, hidden, frac, grs}
  localparam int VEC_W   = FRAC_WIDTH + GRS_WIDTH + 2;
  localparam int SH_W    = VEC_W - 1;
  localparam int SHAMT_W = $clog2(FRAC_WIDTH + GRS_WIDTH + 1);

  typedef struct packed {
    logic [ID_WIDTH-1:0]     id;
    logic                    sign;
    logic signed [EXP_W-1:0] expo;
    logic                    carry;
    logic                    hidden;
    logic [FRAC_WIDTH-1:0]   frac;
    logic [GRS_WIDTH-1:0]    grs;
    logic [SHAMT_W-1:0]      clz;
    logic                    right_shift;
    logic [SHAMT_W-1:0]      right_shift_amt;
    logic [2:0]              rm;
    logic [4:0]              fflags;
  } fp_norm_interm_t;

  typedef struct packed {
    logic                    sign;
    logic signed [EXP_W-1:0] expo;
    logic [MANT_W-1:0]       mant;
    logic [2:0]              grs;
    logic [ID_WIDTH-1:0]     id;
    logic [2:0]              rm;
    logic [4:0]              fflags;
  } fp_norm_result_t;

endpackage

// File: rtl/fp_wb_normalize_if.sv
// Writeback normalize bus: done/ack intermediate input side, valid/ready normalized output side.
interface fp_wb_normalize_if;
  import fpu_types::*;

  logic                    in_done;
  logic                    in_ack;
  logic [ID_WIDTH-1:0]     in_id;
  logic                    in_sign;
  logic signed [EXP_W-1:0] in_expo;
  logic                    in_carry;
  logic                    in_hidden;
  logic [FRAC_WIDTH-1:0]   in_frac;
  logic [GRS_WIDTH-1:0]    in_grs;
  logic [SHAMT_W-1:0]      in_clz;
  logic                    in_right_shift;
  logic [SHAMT_W-1:0]      in_right_shift_amt;
  logic [2:0]              in_rm;
  logic [4:0]              in_fflags;

  logic                    out_valid;
  logic                    out_ready;
  logic [ID_WIDTH-1:0]     out_id;
  logic                    out_sign;
  logic signed [EXP_W-1:0] out_expo;
  logic [MANT_W-1:0]       out_mant;
  logic [2:0]              out_grs;
  logic [2:0]              out_rm;
  logic [4:0]              out_fflags;

  modport slave (
    input  in_done, in_id, in_sign, in_expo, in_carry, in_hidden, in_frac, in_grs,
           in_clz, in_right_shift, in_right_shift_amt, in_rm, in_fflags, out_ready,
    output in_ack, out_valid, out_id, out_sign, out_expo, out_mant, out_grs, out_rm, out_fflags
  );

  modport master (
    output in_done, in_id, in_sign, in_expo, in_carry, in_hidden, in_frac, in_grs,
           in_clz, in_right_shift, in_right_shift_amt, in_rm, in_fflags, out_ready,
    input  in_ack, out_valid, out_id, out_sign, out_expo, out_mant, out_grs, out_rm, out_fflags
  );

endinterface

// File: rtl/fp_wb_normalize_shifter.sv
// fp_norm_shifter: combinational carry / left (clz) / right (subnormal) normalization shift
// with sticky collapse to G/R/S. Shared with the FMA writeback path.
module fp_norm_shifter
  import fpu_types::*;
(
  input  fp_norm_interm_t i_interm,
  output fp_norm_result_t o_result
);

  logic [VEC_W-1:0]   w_vec;
  logic [VEC_W-1:0]   w_lost;
  logic [SH_W-1:0]    w_rsh;
  logic [SH_W-1:0]    w_lsh;
  logic [SH_W-1:0]    w_sh;
  logic [SHAMT_W-1:0] w_ramt;
  logic               w_right;

  assign w_vec   = {i_interm.carry, i_interm.hidden, i_interm.frac, i_interm.grs};
  // carry overflow is just a right shift by one that also bumps the exponent
  assign w_right = i_interm.carry | i_interm.right_shift;
  assign w_ramt  = i_interm.carry ? SHAMT_W'(1) : i_interm.right_shift_amt;

  // After any shift the carry slot is dead, so only the bits below it are kept.
  assign w_rsh  = SH_W'(w_vec >> w_ramt);
  assign w_lsh  = SH_W'(w_vec << i_interm.clz);
  assign w_lost = w_vec & ~({VEC_W{1'b1}} << w_ramt);
  assign w_sh   = w_right ? w_rsh : w_lsh;

  always_comb begin
    o_result        = '0;
    o_result.sign   = i_interm.sign;
    o_result.id     = i_interm.id;
    o_result.rm     = i_interm.rm;
    o_result.fflags = i_interm.fflags;
    if (i_interm.carry)
      o_result.expo = i_interm.expo + EXP_W'(1);
    else if (i_interm.right_shift)
      o_result.expo = i_interm.expo;
    else
      o_result.expo = i_interm.expo - EXP_W'(i_interm.clz);
    o_result.mant = w_sh[SH_W-1 -: MANT_W];
    o_result.grs  = {w_sh[GRS_WIDTH-1], w_sh[GRS_WIDTH-2],
                     (|w_sh[GRS_WIDTH-3:0]) | (w_right & (|w_lost))};
  end

endmodule

// File: rtl/fp_wb_normalize.sv
// Div/sqrt writeback normalize stage: two-entry elastic pipeline (input reg S1, shifter, output reg S2).
// Define FP_WB_NORM_SINGLE_STAGE_EN to drop S1 and place the shifter between the input and S2.
module fp_wb_normalize
  import fpu_types::*;
(
  input  logic               clk,
  input  logic               rst,
  fp_wb_normalize_if.slave   io_wb
);

  fp_norm_interm_t w_in;
  fp_norm_interm_t w_sh_in;
  fp_norm_result_t w_norm;
  fp_norm_result_t r_s2;
  logic            r_s2_valid;
  logic            w_s2_adv;
  logic            w_s2_load;

  always_comb begin
    w_in                 = '0;
    w_in.id              = io_wb.in_id;
    w_in.sign            = io_wb.in_sign;
    w_in.expo            = io_wb.in_expo;
    w_in.carry           = io_wb.in_carry;
    w_in.hidden          = io_wb.in_hidden;
    w_in.frac            = io_wb.in_frac;
    w_in.grs             = io_wb.in_grs;
    w_in.clz             = io_wb.in_clz;
    w_in.right_shift     = io_wb.in_right_shift;
    w_in.right_shift_amt = io_wb.in_right_shift_amt;
    w_in.rm              = io_wb.in_rm;
    w_in.fflags          = io_wb.in_fflags;
  end

  assign w_s2_adv = ~r_s2_valid | io_wb.out_ready;

`ifdef FP_WB_NORM_SINGLE_STAGE_EN
  assign io_wb.in_ack = w_s2_adv;
  assign w_sh_in      = w_in;
  assign w_s2_load    = io_wb.in_done;
`else
  fp_norm_interm_t r_s1;
  logic            r_s1_valid;

  // S1 drains into S2 whenever S2 can take it, so it refills in the same cycle.
  assign io_wb.in_ack = ~r_s1_valid | w_s2_adv;

  always_ff @(posedge clk) begin
    if (!rst)
      r_s1_valid <= 1'b0;
    else if (io_wb.in_ack)
      r_s1_valid <= io_wb.in_done;
  end

  always_ff @(posedge clk) begin
    if (io_wb.in_done && io_wb.in_ack)
      r_s1 <= w_in;
  end

  assign w_sh_in   = r_s1;
  assign w_s2_load = r_s1_valid;
`endif

  fp_norm_shifter u_shifter (
    .i_interm (w_sh_in),
    .o_result (w_norm)
  );

  always_ff @(posedge clk) begin
    if (!rst)
      r_s2_valid <= 1'b0;
    else if (w_s2_adv)
      r_s2_valid <= w_s2_load;
  end

  // Data only moves on advance, so outputs stay put while the rounder stalls.
  always_ff @(posedge clk) begin
    if (w_s2_adv && w_s2_load)
      r_s2 <= w_norm;
  end

  assign io_wb.out_valid  = r_s2_valid;
  assign io_wb.out_id     = r_s2.id;
  assign io_wb.out_sign   = r_s2.sign;
  assign io_wb.out_expo   = r_s2.expo;
  assign io_wb.out_mant   = r_s2.mant;
  assign io_wb.out_grs    = r_s2.grs;
  assign io_wb.out_rm     = r_s2.rm;
  assign io_wb.out_fflags = r_s2.fflags;

endmodule

// File: tb/tb_fp_wb_normalize.sv
// Scoreboard bench for fp_wb_normalize: bit-index reference model, directed corner cases, random traffic.
// Latency expectation follows FP_WB_NORM_SINGLE_STAGE_EN.
module tb_fp_wb_normalize;
  import fpu_types::*;

`ifdef FP_WB_NORM_SINGLE_STAGE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp_wb_normalize_if bus ();

  fp_wb_normalize dut (
    .clk   (clk),
    .rst   (rst),
    .io_wb (bus)
  );

  fp_norm_result_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int n_acc  = 0;
  int n_out  = 0;

  function automatic logic vbit(input logic [VEC_W-1:0] v, input int idx);
    if (idx < 0 || idx >= VEC_W) return 1'b0;
    return v[idx];
  endfunction

  // Result bit j of the shifted vector is source bit j+off; sticky covers every source
  // bit that lands below the round position, including those shifted out entirely.
  function automatic fp_norm_result_t ref_model(input fp_norm_interm_t t);
    fp_norm_result_t r;
    logic [VEC_W-1:0] v;
    int off, e;
    logic st;
    r = '0;
    v = {t.carry, t.hidden, t.frac, t.grs};
    e = int'(t.expo);
    if (t.carry) begin off = 1; e = e + 1; end
    else if (t.right_shift) off = int'(t.right_shift_amt);
    else begin off = -int'(t.clz); e = e - int'(t.clz); end
    r.expo = e[EXP_W-1:0];
    for (int j = 0; j < MANT_W; j++) r.mant[j] = vbit(v, GRS_WIDTH + j + off);
    st = 1'b0;
    for (int k = 0; k < GRS_WIDTH - 2 + off; k++) st = st | vbit(v, k);
    r.grs    = {vbit(v, GRS_WIDTH - 1 + off), vbit(v, GRS_WIDTH - 2 + off), st};
    r.sign   = t.sign;
    r.id     = t.id;
    r.rm     = t.rm;
    r.fflags = t.fflags;
    return r;
  endfunction

  function automatic fp_norm_interm_t rand_item(input int k);
    fp_norm_interm_t t;
    logic [63:0] r64;
    int mode;
    t = '0;
    t.id     = ID_WIDTH'(k);
    t.sign   = 1'($urandom);
    t.expo   = EXP_W'($urandom);
    t.rm     = 3'($urandom);
    t.fflags = 5'($urandom);
    t.hidden = 1'($urandom);
    r64 = {$urandom, $urandom}; t.frac = r64[FRAC_WIDTH-1:0];
    r64 = {$urandom, $urandom}; t.grs  = r64[GRS_WIDTH-1:0];
    if ($urandom_range(0, 3) == 0) begin
      t.frac   = '0;
      t.hidden = 1'b0;
      t.grs    = GRS_WIDTH'(1) << $urandom_range(0, GRS_WIDTH - 1);
    end
    t.clz             = SHAMT_W'($urandom_range(0, ($urandom_range(0, 7) == 0) ? 127 : 12));
    t.right_shift_amt = SHAMT_W'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 127 : 70));
    mode = int'($urandom_range(0, 3));
    t.carry       = (mode == 0);
    t.right_shift = (mode == 1) || (mode == 0 && $urandom_range(0, 1) == 1);
    return t;
  endfunction

  task automatic idle();
    bus.in_done = 1'b0;
  endtask

  // Presents one item and waits for the handshake; returns at posedge+1 after acceptance.
  task automatic send(input fp_norm_interm_t t);
    bit acc;
    int tries;
    bus.in_id = t.id;               bus.in_sign = t.sign;
    bus.in_expo = t.expo;           bus.in_carry = t.carry;
    bus.in_hidden = t.hidden;       bus.in_frac = t.frac;
    bus.in_grs = t.grs;             bus.in_clz = t.clz;
    bus.in_right_shift = t.right_shift;
    bus.in_right_shift_amt = t.right_shift_amt;
    bus.in_rm = t.rm;               bus.in_fflags = t.fflags;
    bus.in_done = 1'b1;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 100) begin
      @(negedge clk);
      acc = bus.in_ack;
      @(posedge clk);
      #1;
      tries++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout id=%0d: in_ack never seen within %0d cycles", t.id, tries);
    end else begin
      exp_q.push_back(ref_model(t));
      n_acc++;
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.out_valid) begin
      checks++; errors++;
      $display("FAIL out_valid_timeout: got 0 after %0d cycles, required 1", lat);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops on every output transfer, and verifies outputs hold while stalled.
  initial begin : monitor
    fp_norm_result_t act, ex, held;
    bit held_v;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        held_v = 1'b0;
        continue;
      end
      act.sign = bus.out_sign;   act.expo = bus.out_expo;
      act.mant = bus.out_mant;   act.grs  = bus.out_grs;
      act.id   = bus.out_id;     act.rm   = bus.out_rm;
      act.fflags = bus.out_fflags;
      if (held_v) begin
        checks++;
        if (!bus.out_valid || act !== held) begin
          errors++;
          $display("FAIL hold_stable: got v=%0b %h, required v=1 %h", bus.out_valid, act, held);
        end
      end
      held_v = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        n_out++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got id=%0d %h, required no output", act.id, act);
        end else begin
          ex = exp_q.pop_front();
          if (act !== ex) begin
            errors++;
            $display("FAIL result id=%0d: got %h, required %h", ex.id, act, ex);
          end
        end
      end else if (bus.out_valid) begin
        held   = act;
        held_v = 1'b1;
      end
    end
  end

  initial begin : stim
    fp_norm_interm_t t;
    int lat, base;
    bit rnd_done;

    bus.in_done = 1'b0;   bus.in_id = '0;      bus.in_sign = 1'b0;
    bus.in_expo = '0;     bus.in_carry = 1'b0; bus.in_hidden = 1'b0;
    bus.in_frac = '0;     bus.in_grs = '0;     bus.in_clz = '0;
    bus.in_right_shift = 1'b0; bus.in_right_shift_amt = '0;
    bus.in_rm = '0;       bus.in_fflags = '0;  bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_in_ack",    64'(bus.in_ack),    64'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    // left normalize by clz
    t = '0;
    t.id = 3'd5; t.expo = 13'sd1000; t.clz = 7'd3;
    t.frac = 52'h2345_6789_ABCD_E; t.grs = 55'h12_3456_789A_BCDE;
    send(t); idle();
    wait_out(lat);
    chk("left_latency", 64'(lat), 64'(LAT));
    chk("left_expo", 64'(bus.out_expo), 64'd997);
    chk("left_mant_msb", 64'(bus.out_mant[MANT_W-1]), 64'd1);
    repeat (2) @(posedge clk); #1;

    // mantissa carry overflow
    t = '0;
    t.id = 3'd6; t.expo = 13'sd1023; t.carry = 1'b1; t.frac = '1;
    t.grs[GRS_WIDTH-1] = 1'b1; t.grs[0] = 1'b1;
    send(t); idle();
    wait_out(lat);
    chk("carry_expo", 64'(bus.out_expo), 64'd1024);
    chk("carry_mant", 64'(bus.out_mant), 64'({2'b10, {(FRAC_WIDTH-1){1'b1}}}));
    chk("carry_grs",  64'(bus.out_grs),  64'd7);
    repeat (2) @(posedge clk); #1;

    // right shifts at and beyond full width
    for (int a = 0; a < 3; a++) begin
      t = rand_item(a);
      t.carry = 1'b0; t.right_shift = 1'b1; t.hidden = 1'b1; t.expo = 13'sd1;
      t.right_shift_amt = (a == 0) ? 7'd60 : (a == 1) ? 7'd109 : 7'd127;
      send(t); idle();
      wait_out(lat);
      chk("right_mant", 64'(bus.out_mant), 64'd0);
      chk("right_grs",  64'(bus.out_grs),  64'd1);
      chk("right_expo", 64'(bus.out_expo), 64'd1);
      repeat (2) @(posedge clk); #1;
    end

    // backpressure: 4 back-to-back with rounder stalled
    bus.out_ready = 1'b0;
    base = n_acc;
    fork
      begin
        for (int i = 0; i < 4; i++) send(rand_item(i));
        idle();
      end
      begin
        repeat (5) @(negedge clk);
        chk("bp_in_ack", 64'(bus.in_ack), 64'd0);
        chk("bp_accepted", 64'(n_acc - base), 64'(LAT));
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk); #1;
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // reset with the pipeline full
    bus.out_ready = 1'b0;
    for (int i = 0; i < LAT; i++) send(rand_item(i));
    idle();
    chk("rst_pre_valid", 64'(bus.out_valid), 64'd1);
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    base = n_out;
    repeat (10) @(posedge clk); #1;
    chk("rst_no_output", 64'(n_out - base), 64'd0);

    // random traffic with random backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 4) == 0) begin
            idle();
            @(posedge clk); #1;
          end
          send(rand_item(i));
        end
        idle();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 2) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("final_drain", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
